// File: rtl/pet_clk_pkg.sv
// Shared types and helpers for the PET2001 clock-enable / reset generator.
// The CPU divisor set stays a top-level parameter list; the helpers here only
// turn that list into the widths and per-rate values the divider needs.
package pet_clk_pkg;

   // Reset sequencer states: power-on hold, stretched hold, normal running.
   typedef enum logic [1:0] {
      POR  = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } rst_state_t;

   localparam int unsigned SPEED_SEL_W = 2;
   localparam int unsigned NUM_RATES   = 2 ** SPEED_SEL_W;

   // Divisor (clk cycles per ce_cpu) for a given rate select.
   function automatic int unsigned cpu_div_of(
      input logic [SPEED_SEL_W-1:0] sel,
      input int unsigned            div_0,
      input int unsigned            div_1,
      input int unsigned            div_2,
      input int unsigned            div_3
   );
      case (sel)
         2'd0:    return div_0;
         2'd1:    return div_1;
         2'd2:    return div_2;
         default: return div_3;
      endcase
   endfunction

   function automatic int unsigned max_of4(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c,
      input int unsigned d
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Bits needed to count 0..v-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/pet_ce_div.sv
// Programmable clock-enable divider.
// The counter runs 0..term, term being (period - 1) of the rate currently
// applied. A new rate select is taken only on the terminal count, so a rate
// change always completes the running period first and no period is ever cut
// short or stretched. The enable pulse is registered and fires on the
// count==0 phase whenever the gate is open; the counter itself never stops,
// so a closed gate suppresses pulses without shifting their phase.
module pet_ce_div
   import pet_clk_pkg::*;
#(
   parameter int unsigned CNT_W = 7,
   parameter int unsigned SEL_W = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [SEL_W-1:0]               sel_in,
   // Entry i, at [i*CNT_W +: CNT_W], holds (period - 1) for rate select i.
   input  logic [(2**SEL_W)*CNT_W-1:0]    term_table,
   input  logic                           gate,
   output logic                           at_zero,
   output logic                           ce,
   output logic [SEL_W-1:0]               sel_active
);

   logic [CNT_W-1:0] ccnt_q, ccnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             ce_q, ce_d;
   logic [CNT_W-1:0] term;
   logic             tc;

   // Next count, rate select and enable pulse.
   always_comb begin
      // NOTE: every signal written here gets a value on every path (the
      // plain assignments below); a path that left one unassigned would
      // make synthesis infer a latch to hold its old value.
      term    = term_table[int'(sel_q) * CNT_W +: CNT_W];
      tc      = (ccnt_q == term);
      at_zero = (ccnt_q == '0);
      ccnt_d  = tc ? '0 : ccnt_q + CNT_W'(1);
      sel_d   = tc ? sel_in : sel_q;
      ce_d    = at_zero & gate;
   end

   // Divider state registers.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge; blocking ones would let later statements see
      // already-updated state and simulate differently from the netlist.
      if (reset) begin
         ccnt_q <= '0;
         sel_q  <= '0;
         ce_q   <= 1'b0;
      end else begin
         ccnt_q <= ccnt_d;
         sel_q  <= sel_d;
         ce_q   <= ce_d;
      end
   end

   assign ce         = ce_q;
   assign sel_active = sel_q;

endmodule

// File: rtl/pet_clk_reset_gen.sv
// Clock-enable and system-reset generator for the PET2001 MiST top level.
// Produces the pixel-rate enables for the video mixer, a CPU enable with four
// selectable rates plus stop / single-step, and a sequenced system reset
// (power-on hold, then a hold stretched past the last reset request).
// All enables keep running while sys_reset is high so the CPU sees clock
// edges during reset. Every CPU_DIV_x must be at least 2.
module pet_clk_reset_gen
   import pet_clk_pkg::*;
#(
   parameter int unsigned PIX_DIV_LOG2 = 3,
   parameter int unsigned CPU_DIV_0    = 112,
   parameter int unsigned CPU_DIV_1    = 31,
   parameter int unsigned CPU_DIV_2    = 56,
   parameter int unsigned CPU_DIV_3    = 14,
   parameter int unsigned POR_CYCLES   = 100000000,
   parameter int unsigned RST_STRETCH  = 15
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rst_req,
   input  logic [SPEED_SEL_W-1:0] speed_sel,
   input  logic                   cpu_stop,
   input  logic                   step,
   output logic                   ce_pix2x,
   output logic                   ce_pix1x_p,
   output logic                   ce_pix1x_n,
   output logic                   ce_cpu,
   output logic                   sys_reset,
   output logic [SPEED_SEL_W-1:0] rate_active
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int unsigned PIX_W     = PIX_DIV_LOG2 + 1;
   localparam int unsigned CPU_CNT_W =
      cnt_width(max_of4(CPU_DIV_0, CPU_DIV_1, CPU_DIV_2, CPU_DIV_3));
   localparam int unsigned RST_CNT_W =
      (cnt_width(POR_CYCLES) > cnt_width(RST_STRETCH)) ?
       cnt_width(POR_CYCLES) : cnt_width(RST_STRETCH);

   localparam logic [PIX_W-1:0] PIX_HALF = {1'b1, {PIX_DIV_LOG2{1'b0}}};

   localparam logic [RST_CNT_W-1:0] POR_LOAD  = RST_CNT_W'(POR_CYCLES - 1);
   localparam logic [RST_CNT_W-1:0] HOLD_LOAD = RST_CNT_W'(RST_STRETCH - 1);

   // Terminal counts (period - 1) for rate selects 3..0, MSB entry first.
   localparam logic [NUM_RATES*CPU_CNT_W-1:0] CPU_TERM_TABLE = {
      CPU_CNT_W'(cpu_div_of(2'd3, CPU_DIV_0, CPU_DIV_1, CPU_DIV_2, CPU_DIV_3) - 1),
      CPU_CNT_W'(cpu_div_of(2'd2, CPU_DIV_0, CPU_DIV_1, CPU_DIV_2, CPU_DIV_3) - 1),
      CPU_CNT_W'(cpu_div_of(2'd1, CPU_DIV_0, CPU_DIV_1, CPU_DIV_2, CPU_DIV_3) - 1),
      CPU_CNT_W'(cpu_div_of(2'd0, CPU_DIV_0, CPU_DIV_1, CPU_DIV_2, CPU_DIV_3) - 1)
   };

   // ------------------------------------------------------------------
   // Pixel divider: free-running, untouched by rst_req / stop / speed
   // ------------------------------------------------------------------
   logic [PIX_W-1:0] pdiv_q, pdiv_d;
   logic             ce_pix2x_q, ce_pix2x_d;
   logic             ce_pix1x_p_q, ce_pix1x_p_d;
   logic             ce_pix1x_n_q, ce_pix1x_n_d;

   // Pixel counter advance and the three pixel-enable decodes.
   always_comb begin
      pdiv_d       = pdiv_q + PIX_W'(1);
      ce_pix2x_d   = (pdiv_q[PIX_DIV_LOG2-1:0] == '0);
      ce_pix1x_p_d = (pdiv_q == '0);
      ce_pix1x_n_d = (pdiv_q == PIX_HALF);
   end

   // ------------------------------------------------------------------
   // CPU enable: stop / single-step gate around the programmable divider
   // ------------------------------------------------------------------
   logic step_prev_q, step_prev_d;
   logic step_pending_q, step_pending_d;
   logic step_edge;
   logic cpu_gate;
   logic cpu_at_zero;
   logic cpu_issue;
   logic ce_cpu_w;
   logic [SPEED_SEL_W-1:0] rate_active_w;

   // Step edge detection and the one-shot pending flag that opens the gate.
   always_comb begin
      step_prev_d = step;
      step_edge   = step & ~step_prev_q;
      cpu_gate    = ~cpu_stop | step_pending_q;
      cpu_issue   = cpu_at_zero & cpu_gate;
      // Issuing a ce_cpu consumes the pending step; further edges seen
      // before that collapse into the same single pulse.
      if (cpu_issue) begin
         step_pending_d = 1'b0;
      end else if (step_edge & cpu_stop) begin
         step_pending_d = 1'b1;
      end else begin
         step_pending_d = step_pending_q;
      end
   end

   pet_ce_div #(
      .CNT_W (CPU_CNT_W),
      .SEL_W (SPEED_SEL_W)
   ) u_cpu_div (
      .clk        (clk),
      .reset      (reset),
      .sel_in     (speed_sel),
      .term_table (CPU_TERM_TABLE),
      .gate       (cpu_gate),
      .at_zero    (cpu_at_zero),
      .ce         (ce_cpu_w),
      .sel_active (rate_active_w)
   );

   // ------------------------------------------------------------------
   // Reset sequencer: POR -> HOLD -> RUN, RUN -> HOLD on rst_req
   // ------------------------------------------------------------------
   rst_state_t             state_q, state_d;
   logic [RST_CNT_W-1:0]   rcnt_q, rcnt_d;
   logic                   sys_reset_q, sys_reset_d;

   // Next-state logic; the counter serves both the POR and the HOLD timing.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         POR: begin
            // rst_req is deliberately ignored until the power-on hold ends.
            if (rcnt_q == '0) begin
               state_d = HOLD;
               rcnt_d  = HOLD_LOAD;
            end else begin
               rcnt_d = rcnt_q - RST_CNT_W'(1);
            end
         end
         HOLD: begin
            if (rst_req) begin
               rcnt_d = HOLD_LOAD;
            end else if (rcnt_q == '0) begin
               state_d = RUN;
            end else begin
               rcnt_d = rcnt_q - RST_CNT_W'(1);
            end
         end
         RUN: begin
            if (rst_req) begin
               state_d = HOLD;
               rcnt_d  = HOLD_LOAD;
            end
         end
         default: begin
            state_d = POR;
            rcnt_d  = POR_LOAD;
         end
      endcase
   end

   // Output decode from the next state, so the registered sys_reset lines up
   // with the state it describes instead of lagging it by one cycle.
   always_comb begin
      sys_reset_d = (state_d != RUN);
   end

   // All registers of this module; async reset restarts the power-on hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pdiv_q         <= '0;
         ce_pix2x_q     <= 1'b0;
         ce_pix1x_p_q   <= 1'b0;
         ce_pix1x_n_q   <= 1'b0;
         step_prev_q    <= 1'b0;
         step_pending_q <= 1'b0;
         state_q        <= POR;
         rcnt_q         <= POR_LOAD;
         sys_reset_q    <= 1'b1;
      end else begin
         pdiv_q         <= pdiv_d;
         ce_pix2x_q     <= ce_pix2x_d;
         ce_pix1x_p_q   <= ce_pix1x_p_d;
         ce_pix1x_n_q   <= ce_pix1x_n_d;
         step_prev_q    <= step_prev_d;
         step_pending_q <= step_pending_d;
         state_q        <= state_d;
         rcnt_q         <= rcnt_d;
         sys_reset_q    <= sys_reset_d;
      end
   end

   assign ce_pix2x    = ce_pix2x_q;
   assign ce_pix1x_p  = ce_pix1x_p_q;
   assign ce_pix1x_n  = ce_pix1x_n_q;
   assign ce_cpu      = ce_cpu_w;
   assign sys_reset   = sys_reset_q;
   assign rate_active = rate_active_w;

endmodule
